mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the fetch stage (instruction port)
//  and the memory stage (data port) of the 5-stage pipeline. Issues one transaction at a time.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  // Transaction sequencer states: sample, hold request until ack, respond.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } arb_state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant after STARVE_LIMIT
// consecutive data wins while a fetch was waiting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned STARVE_LIMIT  = 4,
  localparam int unsigned BE_W         = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_valid,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [ADDRESS_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]    dm_wdata,
  input  logic [BE_W-1:0]          dm_be,
  output logic [DATA_WIDTH-1:0]    dm_rdata,
  output logic                     dm_valid,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [BE_W-1:0]          mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic                     stall_f,
  output logic                     stall_m
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StreakMax = SW'(STARVE_LIMIT);

  arb_state_e               state_q, state_d;
  arb_owner_e               owner_q, owner_d;
  logic                     killed_q, killed_d;
  logic [SW-1:0]            streak_q, streak_d;
  logic                     mem_req_d, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_d;
  logic [BE_W-1:0]          mem_be_d;
  logic [DATA_WIDTH-1:0]    if_rdata_d, dm_rdata_d;
  logic                     if_valid_d, dm_valid_d;
  logic                     owner_req;
  logic                     kill_now;

  // Stalls are purely combinational so the hazard unit sees them in the request cycle.
  assign stall_f = if_req & ~if_valid;
  assign stall_m = dm_req & ~dm_valid;

  // Next-state, arbitration and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    owner_req   = (owner_q == OwnD) ? dm_req : if_req;
    // A drop of the owner's request in the ack cycle itself must also suppress the response.
    kill_now    = killed_q | ~owner_req;

    unique case (state_q)
      StIdle: begin
        if (dm_req && !(if_req && (streak_q == StreakMax))) begin
          owner_d     = OwnD;
          state_d     = StIssue;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          if (if_req && (streak_q != StreakMax)) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (if_req) begin
          owner_d     = OwnI;
          state_d     = StIssue;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          streak_d    = '0;
        end
      end
      StIssue: begin
        killed_d = kill_now;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDone;
          if (owner_q == OwnD) begin
            dm_rdata_d = mem_rdata;
            dm_valid_d = ~kill_now;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = ~kill_now;
          end
        end
      end
      StDone: begin
        killed_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnI;
      killed_q  <= 1'b0;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      killed_q  <= killed_d;
      streak_q  <= streak_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
    end
  end

endmodule
